otter_io_timer: RTL
===================

OTTER_IO_TIMER -- requirements
Module: otter_io_timer

Interface
REQ-001 BASE_ADDR, 32'h1100_0000, word-aligned base of the responder's register window.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 IOBUS_ADDR  input  32  byte address driven by the CPU (memory-stage ALU result).
REQ-005 IOBUS_OUT  input  32  CPU write data.
REQ-006 IOBUS_WR  input  1  CPU write strobe; one write per cycle asserted.
REQ-007 IOBUS_IN  output  32  read data returned to the CPU.
REQ-008 SWITCHES  input  16  asynchronous board switches.
REQ-009 LEDS  output  16  board LEDs.
REQ-010 INTR  output  1  interrupt request to the CPU INTR input.

Function
REQ-011 Decode SHALL hit when IOBUS_ADDR[31:5] equals BASE_ADDR[31:5]; offset is IOBUS_ADDR[4:2]; IOBUS_ADDR[1:0] ignored.
REQ-012 Register map (offset: name, access): 0x00 SW (RO), 0x04 LED (RW, 16b), 0x08 CTRL (RW, bit0 EN, bit1 AUTORELOAD, bit2 IRQEN), 0x0C CMP (RW, 32b), 0x10 CNT (RW, 32b), 0x14 STATUS (bit0 MATCH, write-1-to-clear), 0x18 PRE (RW, 16b).
REQ-013 IOBUS_IN SHALL be combinational from IOBUS_ADDR and current register state (zero-cycle read latency); unused bits, unmapped offsets, and non-hits read 0.
REQ-014 Writes SHALL take effect at the rising edge where IOBUS_WR=1 and decode hits; writes to SW, unmapped offsets, or non-hits SHALL have no effect.
REQ-015 SWITCHES SHALL pass through a two-flop synchronizer; SW reads return the second flop (2-cycle latency from input change).
REQ-016 LEDS SHALL equal the LED register directly.
REQ-017 Prescaler: 16-bit counter PCNT; when EN=1, PCNT increments each cycle; when PCNT==PRE, a tick is generated and PCNT returns to 0 (PRE=0 -> tick every cycle).
REQ-018 When EN=0, PCNT SHALL hold at 0 and CNT SHALL hold.
REQ-019 On tick: if CNT==CMP then MATCH<=1 and CNT<=0 when AUTORELOAD=1, else CNT<=CNT+1 (mod 2^32, wraps 0xFFFF_FFFF->0); if CNT!=CMP, CNT<=CNT+1.
REQ-020 A CPU write to CNT in the same cycle as a tick SHALL win; the tick's increment/match is discarded; PCNT SHALL reset to 0.
REQ-021 A write to PRE SHALL reset PCNT to 0.
REQ-022 STATUS write with bit0=1 clears MATCH; a match in the same cycle SHALL win (MATCH stays 1).
REQ-023 INTR SHALL be a registered one-cycle pulse, asserted the cycle after a tick that sets MATCH while IRQEN=1; no pulse when IRQEN=0, and enabling IRQEN with MATCH already set SHALL NOT pulse.
REQ-024 Matches on consecutive ticks (PRE=0, CMP=0, AUTORELOAD=1) SHALL produce INTR high on each following cycle.

Reset
REQ-025 RESET SHALL asynchronously clear LED, CTRL, CMP, CNT, PRE, PCNT, MATCH, INTR, and synchronizer flops to 0; LEDS=0, INTR=0, IOBUS_IN reflects zeroed state.
REQ-026 RESET asserted mid-count SHALL abort counting immediately; after release, the timer stays idle until EN is written.

Verification
REQ-027 Write 0x0000_A5A5 to BASE+0x04 -> LEDS=16'hA5A5 next cycle; read BASE+0x04 returns 0x0000_A5A5; read BASE+0x1C returns 0.
REQ-028 SWITCHES=16'h1234 -> SW read returns 0 for 2 edges, then 0x0000_1234.
REQ-029 PRE=0, CMP=4, CTRL=0x7 -> CNT 0,1,2,3,4,0,...; MATCH set and INTR pulses one cycle after CNT==4 tick, every 5 cycles.
REQ-030 PRE=2, CMP=1, CTRL=0x1 -> CNT increments every 3 cycles, continues past 1 to 2,3,... with MATCH set once; INTR stays 0.
REQ-031 MATCH=1, STATUS write 0x1 in cycle with new match -> MATCH remains 1; write 0x1 in idle cycle -> MATCH=0.
REQ-032 CNT=0xFFFF_FFFF, CMP=5, EN=1 -> wraps to 0; RESET pulse mid-count -> all registers 0, LEDS=0, INTR=0.

Source files
------------

// File: rtl/otter_io_timer.sv
// rtl/otter_io_timer.sv - OTTER memory-mapped I/O block: switches, LEDs and a prescaled compare timer
// Register window at BASE_ADDR with combinational read-back and a one-cycle interrupt pulse on match.
module otter_io_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  input  logic [15:0] SWITCHES,
  output logic [15:0] LEDS,
  output logic        INTR
);

  localparam logic [2:0] OFF_SW   = 3'd0;
  localparam logic [2:0] OFF_LED  = 3'd1;
  localparam logic [2:0] OFF_CTRL = 3'd2;
  localparam logic [2:0] OFF_CMP  = 3'd3;
  localparam logic [2:0] OFF_CNT  = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_PRE  = 3'd6;

  logic [15:0] led_q, led_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        match_q, match_d;
  logic        intr_q, intr_d;
  logic [15:0] sw_meta_q, sw_sync_q;

  logic       hit, wr_en, tick, cnt_eq, match_evt;
  logic       wr_led, wr_ctrl, wr_cmp, wr_cnt, wr_stat, wr_pre;
  logic [2:0] offset;

  // Byte lane bits are don't-care; the window is word addressed.
  wire unused_addr_bits = ^IOBUS_ADDR[1:0];

  assign hit    = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign offset = IOBUS_ADDR[4:2];
  assign wr_en  = IOBUS_WR && hit;

  assign wr_led  = wr_en && (offset == OFF_LED);
  assign wr_ctrl = wr_en && (offset == OFF_CTRL);
  assign wr_cmp  = wr_en && (offset == OFF_CMP);
  assign wr_cnt  = wr_en && (offset == OFF_CNT);
  assign wr_stat = wr_en && (offset == OFF_STAT);
  assign wr_pre  = wr_en && (offset == OFF_PRE);

  assign tick      = ctrl_q[0] && (pcnt_q == pre_q);
  assign cnt_eq    = (cnt_q == cmp_q);
  // A CPU write to CNT discards the coincident tick, including its match.
  assign match_evt = tick && cnt_eq && !wr_cnt;

  always_comb begin
    led_d   = led_q;
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    pcnt_d  = pcnt_q;
    match_d = match_q;
    intr_d  = match_evt && ctrl_q[2];

    if (wr_led)  led_d  = IOBUS_OUT[15:0];
    if (wr_ctrl) ctrl_d = IOBUS_OUT[2:0];
    if (wr_cmp)  cmp_d  = IOBUS_OUT;
    if (wr_pre)  pre_d  = IOBUS_OUT[15:0];

    if (!ctrl_q[0] || tick || wr_pre || wr_cnt) begin
      pcnt_d = 16'd0;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
    end

    if (wr_cnt) begin
      cnt_d = IOBUS_OUT;
    end else if (tick) begin
      cnt_d = (cnt_eq && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
    end

    // Set beats clear when both land on the same edge.
    if (match_evt) begin
      match_d = 1'b1;
    end else if (wr_stat && IOBUS_OUT[0]) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      led_q     <= 16'd0;
      ctrl_q    <= 3'd0;
      cmp_q     <= 32'd0;
      cnt_q     <= 32'd0;
      pre_q     <= 16'd0;
      pcnt_q    <= 16'd0;
      match_q   <= 1'b0;
      intr_q    <= 1'b0;
      sw_meta_q <= 16'd0;
      sw_sync_q <= 16'd0;
    end else begin
      led_q     <= led_d;
      ctrl_q    <= ctrl_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      pcnt_q    <= pcnt_d;
      match_q   <= match_d;
      intr_q    <= intr_d;
      sw_meta_q <= SWITCHES;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_comb begin
    IOBUS_IN = 32'd0;
    if (hit) begin
      case (offset)
        OFF_SW:   IOBUS_IN = {16'd0, sw_sync_q};
        OFF_LED:  IOBUS_IN = {16'd0, led_q};
        OFF_CTRL: IOBUS_IN = {29'd0, ctrl_q};
        OFF_CMP:  IOBUS_IN = cmp_q;
        OFF_CNT:  IOBUS_IN = cnt_q;
        OFF_STAT: IOBUS_IN = {31'd0, match_q};
        OFF_PRE:  IOBUS_IN = {16'd0, pre_q};
        default:  IOBUS_IN = 32'd0;
      endcase
    end
  end

  assign LEDS = led_q;
  assign INTR = intr_q;

endmodule
